// File: rtl/sm83_bus_pkg.sv
// Shared types for the SM83 data bus bridge: bus-cycle states, transfer
// direction and the all-ones "open bus" value.
package sm83_bus_pkg;

    localparam int BUS_MAX_DW = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRECHG = 2'd1,
        XFER   = 2'd2,
        DONE   = 2'd3
    } bus_state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } bus_dir_t;

    // Undriven bus reads as ones; callers cast the result to their own width.
    function automatic logic [BUS_MAX_DW-1:0] bus_open(input int width);
        logic [BUS_MAX_DW-1:0] v;
        v = '0;
        for (int i = 0; i < BUS_MAX_DW; i++) begin
            if (i < width) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/bus_keeper_reg.sv
// Priority-load keeper register: resets to all ones, load[0] has the highest
// priority, and the value is held when no load is active.
module bus_keeper_reg #(
    parameter int DW   = 8,
    parameter int NSRC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NSRC-1:0]    load,
    input  logic [NSRC*DW-1:0] data,
    output logic [DW-1:0]      q
);

    // Walk from lowest to highest priority so the last matching load wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '1;
        end else begin
            for (int i = NSRC - 1; i >= 0; i--) begin
                if (load[i]) q <= data[i*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/data_bus_bridge.sv
// Clocked bridge between the core internal bus DL and the external data bus D.
// Optional precharge phase enabled by macro DATA_BUS_BRIDGE_PRECHARGE_EN.
module data_bus_bridge
    import sm83_bus_pkg::*;
#(
    parameter int DW       = 8,
    parameter int WAIT_MAX = 3,
    parameter int WCW      = $clog2(WAIT_MAX + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          BusDisable,
    input  logic          Res_to_DL,
    input  logic [DW-1:0] Res,
    input  logic          DataOut,
    input  logic [DW-1:0] DV,
    input  logic          RdReq,
    input  logic          WrReq,
    input  logic          IntSel,
    input  logic [DW-1:0] IntData,
    input  logic          ExtRdy,
    input  logic [DW-1:0] D_in,
    output logic [DW-1:0] D_out,
    output logic          D_oe,
    output logic [DW-1:0] DL,
    output logic          DL_valid,
    output logic          Busy,
    output logic          Err
);

    localparam logic [DW-1:0] BUS_OPEN = DW'(bus_open(DW));

    bus_state_t     state;
    bus_state_t     state_nxt;
    bus_dir_t       dir;
    logic           int_sel;
    logic [DW-1:0]  wr_data;
    logic [WCW-1:0] wait_cnt;
    logic [DW-1:0]  capture;
    logic [DW-1:0]  rd_src;
    logic           req_one;
    logic           req_both;
    logic           xfer_done;
    logic           timeout;
    logic           prechg_ld;
    logic           done_ld;
    logic           cap_src_ld;
    logic           cap_open_ld;

    assign req_one   = RdReq ^ WrReq;
    assign req_both  = RdReq & WrReq;
    assign xfer_done = ExtRdy | BusDisable | ((dir == RD) & int_sel);
    // A ready device still wins on the last permitted wait state.
    assign timeout   = !xfer_done && (wait_cnt == WCW'(WAIT_MAX));
    assign rd_src    = int_sel ? IntData : (BusDisable ? BUS_OPEN : D_in);

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_one) begin
`ifdef DATA_BUS_BRIDGE_PRECHARGE_EN
                    state_nxt = PRECHG;
`else
                    state_nxt = XFER;
`endif
                end
            end
            PRECHG: state_nxt = XFER;
            XFER: begin
                if (xfer_done || timeout) state_nxt = DONE;
            end
            DONE: begin
                // A competing ALU write to DL postpones the read load by a cycle.
                if (!((dir == RD) && Res_to_DL)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Busy        = (state != IDLE);
        D_oe        = (state == XFER) && (dir == WR) && !BusDisable;
        D_out       = ((state == XFER) && (dir == WR)) ? wr_data : BUS_OPEN;
        done_ld     = (state == DONE) && (dir == RD);
        cap_src_ld  = (state == XFER) && (dir == RD) && xfer_done;
        cap_open_ld = (state == XFER) && timeout;
`ifdef DATA_BUS_BRIDGE_PRECHARGE_EN
        prechg_ld   = (state == PRECHG);
`else
        prechg_ld   = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dir      <= RD;
            int_sel  <= 1'b0;
            wr_data  <= BUS_OPEN;
            wait_cnt <= '0;
            Err      <= 1'b0;
            DL_valid <= 1'b0;
        end else begin
            Err      <= ((state == IDLE) && req_both) || ((state == XFER) && timeout);
            DL_valid <= (state == DONE) && (dir == RD) && !Res_to_DL;
            if ((state == IDLE) && req_one) begin
                dir     <= WrReq ? WR : RD;
                int_sel <= IntSel;
                wr_data <= DataOut ? DV : DL;
            end
            if ((state == XFER) && !xfer_done && !timeout) wait_cnt <= wait_cnt + 1'b1;
            else if (state == DONE)                        wait_cnt <= '0;
        end
    end

    bus_keeper_reg #(.DW(DW), .NSRC(3)) u_dl_reg (
        .clk  (CLK),
        .rst  (RESET),
        .load ({prechg_ld, done_ld, Res_to_DL}),
        .data ({BUS_OPEN, capture, Res}),
        .q    (DL)
    );

    bus_keeper_reg #(.DW(DW), .NSRC(2)) u_capture_reg (
        .clk  (CLK),
        .rst  (RESET),
        .load ({cap_open_ld, cap_src_ld}),
        .data ({BUS_OPEN, rd_src}),
        .q    (capture)
    );

endmodule
